mm_core_scheduler: RTL and testbench

Run sequencer and shared-memory arbiter for the multi-core matrix-multiplication processor. Launches a selected set of processor cores through their 2-bit `status` start input and collects each core's `end_process`. While cores run, it shares the single data-memory port among them with a round-robin arbiter. Sits between the host/top-level start logic, the per-core control units and the shared data RAM.

---
 rtl/mm_core_scheduler_pkg.sv | 14 +
 rtl/mm_core_scheduler_if.sv | 29 ++
 rtl/mm_core_scheduler_rr_arbiter.sv | 43 ++++
 rtl/mm_core_scheduler.sv | 115 +++++++++++
 tb/tb_mm_core_scheduler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mm_core_scheduler_pkg.sv
// Shared types and status codes for the multi-core run scheduler.
package mm_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GO   = 2'b01;

endpackage

// File: rtl/mm_core_scheduler_if.sv
// Per-core memory request bus plus the shared RAM port seen by the scheduler.
interface mm_core_scheduler_if #(
  parameter int NCORES = 4,
  parameter int AW     = 16,
  parameter int DW     = 8
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    req_we;
  logic [NCORES*AW-1:0] req_addr;
  logic [NCORES*DW-1:0] req_wdata;
  logic [NCORES-1:0]    gnt;
  logic [NCORES-1:0]    rvalid;
  logic [DW-1:0]        rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mm_core_scheduler_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above ptr wins, with wrap.
module rr_arbiter
  import mm_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          hit;

  always_comb begin
    gnt = '0;
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (en && !hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/mm_core_scheduler.sv
// Run sequencer for the processor cores plus round-robin sharing of the data RAM port.
module mm_core_scheduler
  import mm_sched_pkg::*;
#(
  parameter int                NCORES  = 4,
  parameter int                AW      = 16,
  parameter int                DW      = 8,
  parameter int                TO_W    = 20,
  parameter logic [TO_W-1:0]   TIMEOUT = 20'd1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NCORES-1:0]     core_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [2*NCORES-1:0]   core_status,
  input  logic [NCORES-1:0]     core_end,
  mm_core_scheduler_if.slave    bus
);
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

  state_t            state, state_nxt;
  logic [NCORES-1:0] mask_q, seen, seen_nxt;
  logic [TO_W-1:0]   cnt;
  logic [NCORES-1:0] gnt, rvalid_q;
  logic              all_seen;
  logic              mem_we_c;
  logic [AW-1:0]     mem_addr_c;
  logic [DW-1:0]     mem_wdata_c;

  assign seen_nxt = seen | (core_end & mask_q);
  assign all_seen = (seen_nxt == mask_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = (|core_mask) ? S_LAUNCH : S_DONE;
      S_LAUNCH: state_nxt = S_RUN;
      S_RUN:    if (all_seen || cnt == TO_LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_LAUNCH) || (state == S_RUN);
    done        = (state == S_DONE);
    core_status = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      core_status[2*i +: 2] = (state == S_LAUNCH && mask_q[i]) ? ST_GO : ST_IDLE;
    end
  end

  // Completion is tested before expiry so a final core_end on the last cycle is not an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      seen     <= '0;
      timeout  <= 1'b0;
      cnt      <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt & ~bus.req_we;
      if (state == S_IDLE && start) begin
        mask_q  <= core_mask;
        seen    <= '0;
        timeout <= 1'b0;
      end
      if (state == S_LAUNCH) begin
        cnt <= '0;
      end else if (state == S_RUN) begin
        seen <= seen_nxt;
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (!all_seen && cnt == TO_LAST) timeout <= 1'b1;
      end
    end
  end

  rr_arbiter #(.N(NCORES)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req & mask_q),
    .en    (state == S_RUN),
    .gnt   (gnt)
  );

  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      if (gnt[k]) begin
        mem_we_c    = bus.req_we[k];
        mem_addr_c  = bus.req_addr[k*AW +: AW];
        mem_wdata_c = bus.req_wdata[k*DW +: DW];
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mm_core_scheduler.sv
// Directed bench for mm_core_scheduler: cycle table for the main flows, hand sequences for reset cases.
module tb_mm_core_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] core_mask;
  logic       busy, done, timeout;
  logic [7:0] core_status;
  logic [3:0] core_end;

  int n_chk  = 0;
  int n_fail = 0;

  mm_core_scheduler_if #(.NCORES(4), .AW(16), .DW(8)) bus ();

  mm_core_scheduler #(
    .NCORES (4),
    .AW     (16),
    .DW     (8),
    .TO_W   (20),
    .TIMEOUT(20'd8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .core_mask  (core_mask),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .core_status(core_status),
    .core_end   (core_end),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, 0x11 preloaded with 8'hA5.
  logic [7:0] mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h11]    <= 8'hA5;
      bus.mem_rdata <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  typedef struct {
    logic       start;
    logic [3:0] mask;
    logic [3:0] cend;
    logic [3:0] req;
    logic [3:0] we;
    logic       e_busy;
    logic       e_done;
    logic       e_tmo;
    logic [7:0] e_st;
    logic [3:0] e_gnt;
    logic       e_en;
    logic [15:0] e_addr;
    logic [3:0] e_rv;
    logic       e_rdchk;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic [3:0] m, logic [3:0] ce, logic [3:0] rq,
                              logic [3:0] w, logic b, logic d, logic t, logic [7:0] st,
                              logic [3:0] g, logic en, logic [15:0] a, logic [3:0] rv,
                              logic rc, logic [7:0] rd);
    vec_t v;
    v.start = s;  v.mask = m;   v.cend = ce; v.req = rq; v.we = w;
    v.e_busy = b; v.e_done = d; v.e_tmo = t; v.e_st = st; v.e_gnt = g;
    v.e_en = en;  v.e_addr = a; v.e_rv = rv; v.e_rdchk = rc; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},        32'(busy),          32'd0);
    chk({tag, " done"},        32'(done),          32'd0);
    chk({tag, " timeout"},     32'(timeout),       32'd0);
    chk({tag, " core_status"}, 32'(core_status),   32'd0);
    chk({tag, " gnt"},         32'(bus.gnt),       32'd0);
    chk({tag, " mem_en"},      32'(bus.mem_en),    32'd0);
    chk({tag, " mem_we"},      32'(bus.mem_we),    32'd0);
    chk({tag, " mem_addr"},    32'(bus.mem_addr),  32'd0);
    chk({tag, " mem_wdata"},   32'(bus.mem_wdata), 32'd0);
    chk({tag, " rvalid"},      32'(bus.rvalid),    32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    core_mask     = '0;
    core_end      = '0;
    bus.req       = '0;
    bus.req_we    = '0;
    for (int k = 0; k < 4; k++) begin
      bus.req_addr[k*16 +: 16] = 16'h0010 + 16'(k);
      bus.req_wdata[k*8 +: 8]  = 8'hC0 + 8'(k);
    end

    //        st m      cend     req      we       bsy dn tmo st     gnt     en addr      rv      rc rd
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c0
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 0, 8'h11, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c1 LAUNCH
    tbl.push_back(mk(0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c2
    tbl.push_back(mk(0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c3
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c4 DONE
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c5
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c6
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 8'h55, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c7 LAUNCH
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 1, 0, 0, 8'h00, 4'b0001, 1, 16'h0010, 4'b0000, 0, 8'h00)); // c8
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 1, 0, 0, 8'h00, 4'b0010, 1, 16'h0011, 4'b0000, 0, 8'h00)); // c9
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 1, 0, 0, 8'h00, 4'b0100, 1, 16'h0012, 4'b0010, 1, 8'hA5)); // c10
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 1, 0, 0, 8'h00, 4'b1000, 1, 16'h0013, 4'b0000, 0, 8'h00)); // c11
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 4'b1101, 1, 0, 0, 8'h00, 4'b0001, 1, 16'h0010, 4'b0000, 0, 8'h00)); // c12
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c13
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c14 DONE
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c15
    tbl.push_back(mk(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c16
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 8'h05, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c17 LAUNCH
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c18 RUN 0
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c19
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 1, 0, 0, 8'h00, 4'b0010, 1, 16'h0011, 4'b0000, 0, 8'h00)); // c20
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1, 0, 0, 8'h00, 4'b0001, 1, 16'h0010, 4'b0010, 1, 8'hA5)); // c21
    tbl.push_back(mk(0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0001, 1, 8'hC0)); // c22
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c23
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c24
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c25 RUN 7
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c26 DONE
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c27
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c28 DONE
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 16'h0000, 4'b0000, 0, 8'h00)); // c29

    tick();
    #1;
    chk_reset_outputs("por");
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      start      = tbl[i].start;
      core_mask  = tbl[i].mask;
      core_end   = tbl[i].cend;
      bus.req    = tbl[i].req;
      bus.req_we = tbl[i].we;
      #1;
      chk($sformatf("c%0d busy", i),        32'(busy),         32'(tbl[i].e_busy));
      chk($sformatf("c%0d done", i),        32'(done),         32'(tbl[i].e_done));
      chk($sformatf("c%0d timeout", i),     32'(timeout),      32'(tbl[i].e_tmo));
      chk($sformatf("c%0d core_status", i), 32'(core_status),  32'(tbl[i].e_st));
      chk($sformatf("c%0d gnt", i),         32'(bus.gnt),      32'(tbl[i].e_gnt));
      chk($sformatf("c%0d mem_en", i),      32'(bus.mem_en),   32'(tbl[i].e_en));
      chk($sformatf("c%0d mem_addr", i),    32'(bus.mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("c%0d rvalid", i),      32'(bus.rvalid),   32'(tbl[i].e_rv));
      if (tbl[i].e_rdchk)
        chk($sformatf("c%0d rdata", i),     32'(bus.rdata),    32'(tbl[i].e_rd));
      tick();
    end

    // Reset in the middle of a granted read by core 2
    start = 1'b1; core_mask = 4'b1111; core_end = '0; bus.req = '0; bus.req_we = '0;
    tick();
    start = 1'b0;
    tick();
    bus.req = 4'b0100;
    #1;
    chk("rst gnt core2",  32'(bus.gnt),      32'h4);
    chk("rst addr core2", 32'(bus.mem_addr), 32'h0012);
    tick();
    bus.req = 4'b0000;
    #1;
    chk("rst rvalid pending", 32'(bus.rvalid), 32'h4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    tick();
    rst_n = 1'b1;
    #1;
    chk("post rst rvalid", 32'(bus.rvalid), 32'h0);
    chk("post rst busy",   32'(busy),       32'h0);

    // Pointer must be back at 0, and a write grant drives we/wdata
    start = 1'b1; core_mask = 4'b1111;
    tick();
    start = 1'b0;
    tick();
    bus.req = 4'b1111; bus.req_we = 4'b1111;
    #1;
    chk("ptr reset gnt", 32'(bus.gnt),       32'h1);
    chk("write mem_we",  32'(bus.mem_we),    32'h1);
    chk("write wdata",   32'(bus.mem_wdata), 32'hC0);
    tick();
    #1;
    chk("write no rvalid", 32'(bus.rvalid), 32'h0);
    bus.req = '0; bus.req_we = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
